// File: rtl/mouse_event_bus_bridge_if.sv
// CPU bus and mouse-packet signal bundle for the mouse event bridge.
// The 8-bit tristate data bus stays a plain inout port on the bridge itself.
interface mouse_event_bus_bridge_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;
  logic       PKT_VALID;
  logic [7:0] PKT_STATUS;
  logic [7:0] PKT_DX;
  logic [7:0] PKT_DY;
  logic [7:0] PKT_DZ;

  modport master (
    output BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK,
    output PKT_VALID, PKT_STATUS, PKT_DX, PKT_DY, PKT_DZ,
    input  BUS_INTERRUPT_RAISE
  );

  modport slave (
    input  BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK,
    input  PKT_VALID, PKT_STATUS, PKT_DX, PKT_DY, PKT_DZ,
    output BUS_INTERRUPT_RAISE
  );
endinterface

// File: rtl/mouse_event_bus_bridge.sv
// Memory-mapped bridge buffering mouse packets in a FIFO for CPU readout,
// with fill-level interrupt, flush and sticky overflow.
module mouse_event_bus_bridge #(
  parameter logic [7:0]  BASE_ADDR  = 8'hA0,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_W      = 3,
  parameter int unsigned IRQ_THRESH = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  inout  wire  [7:0]               BUS_DATA,
  mouse_event_bus_bridge_if.slave  bus
);

  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 32;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               irq_en;
  logic               overflow;
  logic               irq;
  logic               drive_en;
  logic [7:0]         rd_data;

  logic               in_win;
  logic               bus_rd;
  logic               bus_wr;
  logic [2:0]         offset;
  logic               empty;
  logic               full;
  logic               ctrl_wr;
  logic               flush;
  logic               ovf_clr;
  logic               pop_ok;
  logic               push_ok;
  logic               ovf_set;
  logic               irq_set;
  logic [CNT_W-1:0]   post_cnt;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] pkt_entry;
  logic [7:0]         rd_mux;
  logic               unused_wdata;

  assign in_win       = (bus.BUS_ADDR[7:3] == BASE_ADDR[7:3]);
  assign offset       = bus.BUS_ADDR[2:0];
  assign bus_rd       = in_win & ~bus.BUS_WE;
  assign bus_wr       = in_win & bus.BUS_WE;
  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign pkt_entry    = {bus.PKT_STATUS, bus.PKT_DX, bus.PKT_DY, bus.PKT_DZ};
  assign unused_wdata = ^BUS_DATA[7:3];

  // Control decode: flush overrides both push and pop in its cycle
  always_comb begin
    ctrl_wr  = bus_wr && (offset == 3'd5);
    flush    = ctrl_wr && BUS_DATA[1];
    ovf_clr  = ctrl_wr && BUS_DATA[2];
    pop_ok   = bus_wr && (offset == 3'd7) && !empty && !flush;
    push_ok  = bus.PKT_VALID && !flush && (!full || pop_ok);
    ovf_set  = bus.PKT_VALID && !flush && full && !pop_ok;
    post_cnt = count + CNT_W'(1) - CNT_W'(pop_ok);
    irq_set  = push_ok && irq_en && (post_cnt >= CNT_W'(IRQ_THRESH));
  end

  // Register read mux; head bytes read zero while the FIFO is empty
  always_comb begin
    head   = mem[rd_ptr];
    rd_mux = 8'h00;
    case (offset)
      3'd0:    rd_mux = empty ? 8'h00 : head[31:24];
      3'd1:    rd_mux = empty ? 8'h00 : head[23:16];
      3'd2:    rd_mux = empty ? 8'h00 : head[15:8];
      3'd3:    rd_mux = empty ? 8'h00 : head[7:0];
      3'd4:    rd_mux = 8'(count);
      3'd5:    rd_mux = {7'b0, irq_en};
      3'd6:    rd_mux = {4'b0, irq, overflow, full, empty};
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      irq_en   <= 1'b1;
      overflow <= 1'b0;
      irq      <= 1'b0;
      drive_en <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      drive_en <= bus_rd;
      rd_data  <= rd_mux;
      if (ctrl_wr) irq_en <= BUS_DATA[0];
      overflow <= ovf_set | (overflow & ~ovf_clr);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
      // Set beats acknowledge; flush beats both
      if (flush)                      irq <= 1'b0;
      else if (irq_set)               irq <= 1'b1;
      else if (bus.BUS_INTERRUPT_ACK) irq <= 1'b0;
    end
  end

  // Packet storage carries no reset; count gates its visibility
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= pkt_entry;
  end

  assign bus.BUS_INTERRUPT_RAISE = irq;
  assign BUS_DATA = drive_en ? rd_data : {8{1'bz}};

endmodule

// File: tb/tb_mouse_event_bus_bridge.sv
// Directed bench: bridge A at 8'hA0 (IRQ_THRESH=1) and bridge B at 8'hB0
// (IRQ_THRESH=4) share the CPU bus and packet stimulus.
module tb_mouse_event_bus_bridge;
  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic       we;
  logic       oe;
  logic [7:0] wdata;
  logic       ack;
  logic       pkt_valid;
  logic [31:0] pkt;
  wire  [7:0] bus_data;

  int checks;
  int errors;

  mouse_event_bus_bridge_if ifa ();
  mouse_event_bus_bridge_if ifb ();

  assign bus_data = oe ? wdata : {8{1'bz}};

  assign ifa.BUS_ADDR          = addr;
  assign ifa.BUS_WE            = we;
  assign ifa.BUS_INTERRUPT_ACK = ack;
  assign ifa.PKT_VALID         = pkt_valid;
  assign ifa.PKT_STATUS        = pkt[31:24];
  assign ifa.PKT_DX            = pkt[23:16];
  assign ifa.PKT_DY            = pkt[15:8];
  assign ifa.PKT_DZ            = pkt[7:0];
  assign ifb.BUS_ADDR          = addr;
  assign ifb.BUS_WE            = we;
  assign ifb.BUS_INTERRUPT_ACK = ack;
  assign ifb.PKT_VALID         = pkt_valid;
  assign ifb.PKT_STATUS        = pkt[31:24];
  assign ifb.PKT_DX            = pkt[23:16];
  assign ifb.PKT_DY            = pkt[15:8];
  assign ifb.PKT_DZ            = pkt[7:0];

  mouse_event_bus_bridge #(.BASE_ADDR(8'hA0), .DEPTH(8), .PTR_W(3), .IRQ_THRESH(1)) dut_a (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .bus(ifa.slave));

  mouse_event_bus_bridge #(.BASE_ADDR(8'hB0), .DEPTH(8), .PTR_W(3), .IRQ_THRESH(4)) dut_b (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Read: address in cycle N, data sampled in N+1, then one idle cycle to release the bus
  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    addr = a;
    we   = 1'b0;
    tick();
    d    = bus_data;
    addr = 8'h00;
    tick();
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr  = a;
    we    = 1'b1;
    oe    = 1'b1;
    wdata = d;
    tick();
    addr  = 8'h00;
    we    = 1'b0;
    oe    = 1'b0;
  endtask

  task automatic push(input logic [31:0] p);
    pkt       = p;
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    checks++;
    if (ifa.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %0b expected 0", ifa.BUS_INTERRUPT_RAISE);
    end
    bus_read(8'hA6, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL reset_flags: got %h expected 01", d);
    end
    bus_read(8'hA5, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL reset_ctrl: got %h expected 01", d);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(8'hA0 + 8'(i), d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL reset_head%0d: got %h expected 00", i, d);
      end
    end
  endtask

  task automatic test_single_push();
    logic [7:0] d;
    logic [7:0] exp [4];
    exp[0] = 8'h81; exp[1] = 8'h05; exp[2] = 8'hFB; exp[3] = 8'h00;
    do_reset();
    push(32'h8105FB00);
    checks++;
    if (ifa.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++;
      $display("FAIL push_irq_rise: got %0b expected 1", ifa.BUS_INTERRUPT_RAISE);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(8'hA0 + 8'(i), d);
      checks++;
      if (d !== exp[i]) begin
        errors++;
        $display("FAIL push_head%0d: got %h expected %h", i, d, exp[i]);
      end
    end
    bus_write(8'hA4, 8'hFF);
    bus_read(8'hA4, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL push_count_ro: got %h expected 01", d);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (ifa.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear: got %0b expected 0", ifa.BUS_INTERRUPT_RAISE);
    end
    bus_read(8'hA6, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL push_flags: got %h expected 00", d);
    end
    bus_write(8'hA7, 8'h5A);
    bus_read(8'hA6, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL pop_flags: got %h expected 01", d);
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] d;
    logic [31:0] p;
    do_reset();
    for (int i = 0; i < 9; i++) push({8'h10 + 8'(i), 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)});
    bus_read(8'hA4, d);
    checks++;
    if (d !== 8'h08) begin
      errors++;
      $display("FAIL full_count: got %h expected 08", d);
    end
    bus_read(8'hA6, d);
    checks++;
    if (d !== 8'h0E) begin
      errors++;
      $display("FAIL full_flags: got %h expected 0e", d);
    end
    for (int i = 0; i < 8; i++) begin
      p = {8'h10 + 8'(i), 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)};
      for (int b = 0; b < 4; b++) begin
        bus_read(8'hA0 + 8'(b), d);
        checks++;
        if (d !== p[31 - 8*b -: 8]) begin
          errors++;
          $display("FAIL order_pkt%0d_byte%0d: got %h expected %h", i, b, d, p[31 - 8*b -: 8]);
        end
      end
      bus_write(8'hA7, 8'h00);
    end
    bus_read(8'hA6, d);
    checks++;
    if (d !== 8'h0D) begin
      errors++;
      $display("FAIL drained_flags: got %h expected 0d", d);
    end
    bus_write(8'hA5, 8'h05);
    bus_read(8'hA6, d);
    checks++;
    if (d !== 8'h09) begin
      errors++;
      $display("FAIL ovf_clr_flags: got %h expected 09", d);
    end
    bus_read(8'hA5, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL ovf_clr_ctrl: got %h expected 01", d);
    end
    bus_write(8'hA7, 8'h00);
    bus_read(8'hA4, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL empty_pop_count: got %h expected 00", d);
    end
    push(32'h77665544);
    bus_read(8'hA1, d);
    checks++;
    if (d !== 8'h66) begin
      errors++;
      $display("FAIL after_empty_pop_dx: got %h expected 66", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 8; i++) push({8'h40 + 8'(i), 8'h01, 8'h02, 8'h03});
    pkt       = 32'hEE010203;
    pkt_valid = 1'b1;
    addr      = 8'hA7;
    we        = 1'b1;
    oe        = 1'b1;
    wdata     = 8'h00;
    tick();
    pkt_valid = 1'b0;
    addr      = 8'h00;
    we        = 1'b0;
    oe        = 1'b0;
    bus_read(8'hA4, d);
    checks++;
    if (d !== 8'h08) begin
      errors++;
      $display("FAIL b2b_count: got %h expected 08", d);
    end
    bus_read(8'hA6, d);
    checks++;
    if (d !== 8'h0A) begin
      errors++;
      $display("FAIL b2b_flags: got %h expected 0a", d);
    end
    for (int i = 0; i < 8; i++) begin
      exp = (i == 7) ? 8'hEE : 8'h41 + 8'(i);
      bus_read(8'hA0, d);
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL b2b_order%0d: got %h expected %h", i, d, exp);
      end
      bus_write(8'hA7, 8'h00);
    end
    bus_read(8'hA6, d);
    checks++;
    if (d !== 8'h09) begin
      errors++;
      $display("FAIL b2b_drained_flags: got %h expected 09", d);
    end
  endtask

  task automatic test_flush();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 5; i++) push({8'h60 + 8'(i), 8'h00, 8'h00, 8'h00});
    checks++;
    if (ifa.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_irq: got %0b expected 1", ifa.BUS_INTERRUPT_RAISE);
    end
    pkt       = 32'hDD000000;
    pkt_valid = 1'b1;
    bus_write(8'hA5, 8'h02);
    pkt_valid = 1'b0;
    checks++;
    if (ifa.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++;
      $display("FAIL flush_irq: got %0b expected 0", ifa.BUS_INTERRUPT_RAISE);
    end
    bus_read(8'hA4, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL flush_count: got %h expected 00", d);
    end
    bus_read(8'hA0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL flush_head: got %h expected 00", d);
    end
    bus_read(8'hA6, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL flush_flags: got %h expected 01", d);
    end
    bus_read(8'hA5, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL flush_ctrl: got %h expected 00", d);
    end
    push(32'h9A000000);
    checks++;
    if (ifa.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++;
      $display("FAIL irq_disabled: got %0b expected 0", ifa.BUS_INTERRUPT_RAISE);
    end
    bus_read(8'hA0, d);
    checks++;
    if (d !== 8'h9A) begin
      errors++;
      $display("FAIL flush_repush_head: got %h expected 9a", d);
    end
    bus_write(8'hA5, 8'h01);
    push(32'h9B000000);
    bus_write(8'hA5, 8'h00);
    checks++;
    if (ifa.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++;
      $display("FAIL irq_en_off_keeps: got %0b expected 1", ifa.BUS_INTERRUPT_RAISE);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ifa.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++;
      $display("FAIL midreset_irq: got %0b expected 0", ifa.BUS_INTERRUPT_RAISE);
    end
    bus_read(8'hA4, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL midreset_count: got %h expected 00", d);
    end
    bus_read(8'hA5, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL midreset_ctrl: got %h expected 01", d);
    end
  endtask

  task automatic test_thresh();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push({8'hC0 + 8'(i), 8'h00, 8'h00, 8'h00});
      checks++;
      if (ifb.BUS_INTERRUPT_RAISE !== 1'b0) begin
        errors++;
        $display("FAIL thresh_below%0d: got %0b expected 0", i + 1, ifb.BUS_INTERRUPT_RAISE);
      end
    end
    push(32'hC3000000);
    checks++;
    if (ifb.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++;
      $display("FAIL thresh_hit: got %0b expected 1", ifb.BUS_INTERRUPT_RAISE);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (ifb.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++;
      $display("FAIL thresh_ack: got %0b expected 0", ifb.BUS_INTERRUPT_RAISE);
    end
    ack = 1'b1;
    push(32'hC4000000);
    ack = 1'b0;
    checks++;
    if (ifb.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_ack: got %0b expected 1", ifb.BUS_INTERRUPT_RAISE);
    end
    bus_read(8'hB4, d);
    checks++;
    if (d !== 8'h05) begin
      errors++;
      $display("FAIL thresh_count: got %h expected 05", d);
    end
    bus_read(8'hB0, d);
    checks++;
    if (d !== 8'hC0) begin
      errors++;
      $display("FAIL thresh_head: got %h expected c0", d);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    addr      = 8'h00;
    we        = 1'b0;
    oe        = 1'b0;
    wdata     = 8'h00;
    ack       = 1'b0;
    pkt_valid = 1'b0;
    pkt       = 32'h0;
    tick();
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_back_to_back();
    test_flush();
    test_thresh();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
